// File: rtl/seq_control_unit_if.sv
// -----------------------------------------------------------------------------
// seq_control_unit_if
//   Bundle between the instruction sequencer and the rest of the 4-bit core
//   (program memory, PC, accumulator, ALU). clk/rst_n stay plain module ports.
//
//   Handshake: the sequencer raises mem_req while it waits for an opcode;
//   memory answers with mem_ack for one cycle with instr_in valid in that same
//   cycle. mem_ack is only meaningful while mem_req is high and is ignored at
//   all other times. There is no backpressure on the strobes: each strobe is a
//   single-cycle command that the consumer must take in the cycle it is high.
//
//   master modport : the sequencer (seq_control_unit)
//   slave  modport : memory / datapath side
//
//   Signals
//     mem_ack, instr_in  memory -> sequencer   fetch answer
//     zero, carry        datapath -> sequencer ALU flags (carry only used when
//                                              CTRL_CARRY_EN is defined)
//     resume             env -> sequencer      one-cycle pulse leaving HALT
//     mem_req            sequencer -> memory   fetch request
//     ir                 instruction register
//     load_acc, alu_enable, alu_op, jump, pc_inc   execute strobes
//     halted, illegal    status
//     retire_cnt         retired-instruction counter
//     dbg_state          current FSM state (00 FETCH, 01 DECODE, 10 EXECUTE,
//                        11 HALT) for checkers
// -----------------------------------------------------------------------------
interface seq_control_unit_if #(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 8
);
  logic                mem_ack;
  logic [OPCODE_W-1:0] instr_in;
  logic                zero;
  logic                carry;
  logic                resume;
  logic                mem_req;
  logic [OPCODE_W-1:0] ir;
  logic                load_acc;
  logic                alu_enable;
  logic [1:0]          alu_op;
  logic                jump;
  logic                pc_inc;
  logic                halted;
  logic                illegal;
  logic [CNT_W-1:0]    retire_cnt;
  logic [1:0]          dbg_state;

  modport master (
    input  mem_ack, instr_in, zero, carry, resume,
    output mem_req, ir, load_acc, alu_enable, alu_op, jump, pc_inc,
           halted, illegal, retire_cnt, dbg_state
  );

  modport slave (
    output mem_ack, instr_in, zero, carry, resume,
    input  mem_req, ir, load_acc, alu_enable, alu_op, jump, pc_inc,
           halted, illegal, retire_cnt, dbg_state
  );
endinterface

// File: rtl/seq_control_unit.sv
// -----------------------------------------------------------------------------
// seq_control_unit
//   Multi-cycle FETCH / DECODE / EXECUTE sequencer for the 4-bit processor.
//   Owns the instruction register, issues each instruction's strobes for
//   exactly one cycle (EXECUTE), supports HLT/resume and counts retired
//   instructions.
//
//   Parameters
//     OPCODE_W  opcode width (>= 4); any opcode with bits above bit 3 set is
//               undefined.
//     CNT_W     retired-instruction counter width (wraps modulo 2^CNT_W).
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    seq_control_unit_if.master (handshake, flags, strobes, status)
//
//   Optional feature macro: CTRL_CARRY_EN
//     defined   : opcode 1001 is JC (jump if carry, else pc_inc)
//     undefined : opcode 1001 is illegal and the carry input is unused
//
//   Cycle shape: FETCH (+1 per missing mem_ack) -> DECODE -> EXECUTE -> FETCH,
//   or EXECUTE(HLT) -> HALT until resume. mem_req and halted decode the state
//   directly; execute strobes decode ir plus the flags seen in EXECUTE, so a
//   flag change between fetch and execute is honoured.
// -----------------------------------------------------------------------------
module seq_control_unit #(
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_control_unit_if.master   bus
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'b00,
    S_DECODE  = 2'b01,
    S_EXECUTE = 2'b10,
    S_HALT    = 2'b11
  } state_t;

  state_t              r_state;
  logic [OPCODE_W-1:0] r_ir;
  logic [CNT_W-1:0]    r_retire_cnt;

  logic       w_upper_zero;
  logic       w_is_hlt;
  logic       w_load_acc;
  logic       w_alu_enable;
  logic [1:0] w_alu_op;
  logic       w_jump;
  logic       w_pc_inc;
  logic       w_illegal;

`ifndef CTRL_CARRY_EN
  // carry has no consumer in this build.
  logic w_unused_carry;
  assign w_unused_carry = bus.carry;
`endif

  // Bits above the 4-bit opcode field must be zero for a defined opcode.
  assign w_upper_zero = ((r_ir >> 4) == '0);
  assign w_is_hlt     = w_upper_zero && (r_ir[3:0] == 4'hF);

  // Execute decode. pc_inc is the default action; taken branches swap it for
  // jump, so the two can never be high together.
  always_comb begin
    w_load_acc   = 1'b0;
    w_alu_enable = 1'b0;
    w_alu_op     = 2'b00;
    w_jump       = 1'b0;
    w_pc_inc     = 1'b0;
    w_illegal    = 1'b0;
    if (r_state == S_EXECUTE) begin
      w_pc_inc = 1'b1;
      if (!w_upper_zero) begin
        w_illegal = 1'b1;
      end else begin
        case (r_ir[3:0])
          4'h0: ;                                       // NOP
          4'h1: w_load_acc = 1'b1;                      // LDI
          4'h2: begin w_alu_enable = 1'b1; w_alu_op = 2'b00; end  // ADD
          4'h3: begin w_alu_enable = 1'b1; w_alu_op = 2'b01; end  // SUB
          4'h4: begin w_alu_enable = 1'b1; w_alu_op = 2'b10; end  // AND
          4'h5: begin w_alu_enable = 1'b1; w_alu_op = 2'b11; end  // OR
          4'h7: begin w_jump = 1'b1; w_pc_inc = 1'b0; end         // JMP
          4'h8: begin                                             // JZ
            if (bus.zero) begin
              w_jump   = 1'b1;
              w_pc_inc = 1'b0;
            end
          end
`ifdef CTRL_CARRY_EN
          4'h9: begin                                             // JC
            if (bus.carry) begin
              w_jump   = 1'b1;
              w_pc_inc = 1'b0;
            end
          end
`endif
          4'hF: ;                                       // HLT (pc_inc only)
          default: w_illegal = 1'b1;                    // undefined -> NOP
        endcase
      end
    end
  end

  // Sequencer FSM, instruction register and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_ir         <= '0;
      r_retire_cnt <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.mem_ack) begin
            r_ir    <= bus.instr_in;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: r_state <= S_EXECUTE;
        S_EXECUTE: begin
          r_retire_cnt <= r_retire_cnt + 1'b1;
          // resume seen in this cycle is deliberately not looked at.
          r_state      <= w_is_hlt ? S_HALT : S_FETCH;
        end
        S_HALT: begin
          if (bus.resume) r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign bus.mem_req    = (r_state == S_FETCH);
  assign bus.halted     = (r_state == S_HALT);
  assign bus.ir         = r_ir;
  assign bus.load_acc   = w_load_acc;
  assign bus.alu_enable = w_alu_enable;
  assign bus.alu_op     = w_alu_op;
  assign bus.jump       = w_jump;
  assign bus.pc_inc     = w_pc_inc;
  assign bus.illegal    = w_illegal;
  assign bus.retire_cnt = r_retire_cnt;
  assign bus.dbg_state  = r_state;

endmodule
